// File: rtl/rev_serial_shifter.sv
// Multi-cycle shifter that moves one bit per clock: SRL, SLA with sticky
// overflow, ROL, and a pass-through mode, under a start/busy/done handshake.
module rev_serial_shifter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [CNT_W-1:0] shift_val,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shift_out,
  output logic             ovf
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] MODE_SRL = 2'd0;
  localparam logic [1:0] MODE_SLA = 2'd1;
  localparam logic [1:0] MODE_ROL = 2'd2;

  // Handshake: a start is accepted only in IDLE or DONE; busy marks RUN,
  // done is a one-cycle pulse during which shift_out and ovf are final.
  logic [1:0]       state;
  logic [WIDTH-1:0] data_reg;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_reg;
  logic             ovf_reg;

  logic             accept;
  logic [WIDTH-1:0] step_data;
  logic             step_ovf;

  assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

  always_comb begin
    step_data = data_reg;
    step_ovf  = 1'b0;
    case (mode_reg)
      MODE_SRL: step_data = {1'b0, data_reg[WIDTH-1:1]};
      MODE_SLA: begin
        step_data = {data_reg[WIDTH-2:0], 1'b0};
        // Overflow when the sign bit would change, judged before the shift.
        step_ovf  = data_reg[WIDTH-1] ^ data_reg[WIDTH-2];
      end
      MODE_ROL: step_data = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
      default:  step_data = data_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      data_reg <= '0;
      cnt      <= '0;
      mode_reg <= '0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          data_reg <= step_data;
          cnt      <= cnt - CNT_W'(1);
          ovf_reg  <= ovf_reg | step_ovf;
          if (cnt == CNT_W'(1)) state <= ST_DONE;
        end
        default: begin
          if (accept) begin
            data_reg <= shift_in;
            cnt      <= shift_val;
            mode_reg <= mode;
            ovf_reg  <= 1'b0;
            state    <= (shift_val == '0) ? ST_DONE : ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign shift_out = data_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_rev_serial_shifter.sv
// Directed bench for rev_serial_shifter with hand-computed results, latency,
// busy-length, back-to-back, ignored-start and asynchronous-reset checks.
module tb_rev_serial_shifter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] shift_in;
  logic [3:0]  shift_val;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] shift_out;
  logic        ovf;

  int checks   = 0;
  int failures = 0;
  int cyc;
  int bcnt;

  rev_serial_shifter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .shift_in  (shift_in),
    .shift_val (shift_val),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .shift_out (shift_out),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives a start for one edge; caller must already be at a negedge.
  task automatic issue_now(input logic [15:0] din, input logic [3:0] n, input logic [1:0] m);
    start     = 1'b1;
    shift_in  = din;
    shift_val = n;
    mode      = m;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts negedges after the accepting edge until done; c equals N on success.
  task automatic wait_done(output int c, output int b);
    c = 0;
    b = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) b++;
      c++;
    end
    if (c >= 40) check("timeout_done", 32'(c), 32'd0);
  endtask

  task automatic run_op(input logic [15:0] din, input logic [3:0] n, input logic [1:0] m,
                        output int c, output int b);
    @(negedge clk);
    issue_now(din, n, m);
    wait_done(c, b);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; shift_in = '0; shift_val = '0; mode = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out", 32'(shift_out), 32'h0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h8001, 4'd4, 2'd0, cyc, bcnt);
    check("srl_lat", 32'(cyc), 32'd4);
    check("srl_busy", 32'(bcnt), 32'd4);
    check("srl_out", 32'(shift_out), 32'h0800);
    check("srl_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    check("srl_done_pulse", 32'(done), 32'd0);
    check("srl_hold", 32'(shift_out), 32'h0800);

    run_op(16'h8001, 4'd1, 2'd2, cyc, bcnt);
    check("rol1_out", 32'(shift_out), 32'h0003);
    check("rol1_lat", 32'(cyc), 32'd1);

    run_op(16'h1234, 4'd8, 2'd2, cyc, bcnt);
    check("rol8_out", 32'(shift_out), 32'h3412);
    check("rol8_lat", 32'(cyc), 32'd8);
    check("rol8_busy", 32'(bcnt), 32'd8);
    check("rol8_ovf", 32'(ovf), 32'd0);

    run_op(16'h4000, 4'd1, 2'd1, cyc, bcnt);
    check("sla_4000_out", 32'(shift_out), 32'h8000);
    check("sla_4000_ovf", 32'(ovf), 32'd1);

    run_op(16'hFFF0, 4'd3, 2'd1, cyc, bcnt);
    check("sla_fff0_out", 32'(shift_out), 32'hFF80);
    check("sla_fff0_ovf", 32'(ovf), 32'd0);
    check("sla_fff0_lat", 32'(cyc), 32'd3);

    @(negedge clk);
    issue_now(16'h2000, 4'd3, 2'd1);
    @(negedge clk);
    check("sla_2000_ovf_clr", 32'(ovf), 32'd0);
    @(negedge clk);
    check("sla_2000_ovf_s1", 32'(ovf), 32'd0);
    @(negedge clk);
    check("sla_2000_ovf_s2", 32'(ovf), 32'd1);
    wait_done(cyc, bcnt);
    check("sla_2000_out", 32'(shift_out), 32'h0000);
    check("sla_2000_ovf", 32'(ovf), 32'd1);

    for (int m = 0; m < 4; m++) begin
      run_op(16'hA5A5, 4'd0, 2'(m), cyc, bcnt);
      check($sformatf("zero_lat_m%0d", m), 32'(cyc), 32'd0);
      check($sformatf("zero_busy_m%0d", m), 32'(bcnt), 32'd0);
      check($sformatf("zero_out_m%0d", m), 32'(shift_out), 32'hA5A5);
      check($sformatf("zero_ovf_m%0d", m), 32'(ovf), 32'd0);
    end

    run_op(16'hA5A5, 4'd5, 2'd3, cyc, bcnt);
    check("m3_out", 32'(shift_out), 32'hA5A5);
    check("m3_lat", 32'(cyc), 32'd5);
    check("m3_ovf", 32'(ovf), 32'd0);

    @(negedge clk);
    issue_now(16'hF0F0, 4'd6, 2'd0);
    @(negedge clk);
    start = 1'b1; shift_in = 16'hFFFF; shift_val = 4'd1; mode = 2'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    check("ignore_out", 32'(shift_out), 32'h03C3);
    check("ignore_ovf", 32'(ovf), 32'd0);

    run_op(16'h8001, 4'd1, 2'd2, cyc, bcnt);
    check("b2b_first_out", 32'(shift_out), 32'h0003);
    issue_now(16'h0001, 4'd1, 2'd0);
    wait_done(cyc, bcnt);
    check("b2b_lat", 32'(cyc), 32'd1);
    check("b2b_busy", 32'(bcnt), 32'd1);
    check("b2b_out", 32'(shift_out), 32'h0000);

    @(negedge clk);
    issue_now(16'h4001, 4'd10, 2'd1);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_out", 32'(shift_out), 32'h0);
    check("async_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    check("rst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 32'({busy, done}), 32'd0);
    run_op(16'h8001, 4'd4, 2'd0, cyc, bcnt);
    check("post_rst_out", 32'(shift_out), 32'h0800);
    check("post_rst_lat", 32'(cyc), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rev_serial_shifter.md
# rev_serial_shifter

Multi-cycle shift unit that performs the opposite-direction operations of the execute stage's single-cycle shifter: shift right logical, shift left arithmetic with overflow detect, and rotate left. It shifts one bit position per clock under a start/busy/done handshake. It sits beside the execute-stage ALU and serves microcoded and extended instructions that can tolerate variable latency, so the single-cycle datapath stays narrow.

## Interface
Parameters:
- WIDTH, 16, data width; fixed at 16 for this CPU.
- CNT_W, 4, width of the shift-amount field.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- shift_in  input  16  operand, latched on an accepted start.
- shift_val  input  4  unsigned shift amount 0..15, latched on an accepted start.
- mode  input  2  0 = SRL, 1 = SLA, 2 = ROL, 3 = reserved (pass-through); latched on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; high only in DONE.
- shift_out  output  16  result register; holds its value until the next accepted start.
- ovf  output  1  sticky SLA overflow flag, valid while done is high and held afterwards.

## Operation
- States: IDLE, RUN, DONE. The reset state is IDLE.
- Accepted start, from IDLE or DONE:
  - data_reg <= shift_in; cnt <= shift_val; mode_reg <= mode; ovf <= 0.
  - Next state is DONE if shift_val == 0, otherwise RUN.
- RUN, on each clock:
  - data_reg <= step(data_reg, mode_reg); cnt <= cnt - 1.
  - If cnt == 1, go to DONE; otherwise stay in RUN.
- step definitions:
  - SRL: {1'b0, d[15:1]}.
  - SLA: {d[14:0], 1'b0}. ovf |= d[15] ^ d[14], evaluated on the pre-shift value.
  - ROL: {d[14:0], d[15]}.
  - mode 3: d unchanged. The cycle count is unchanged and ovf stays 0.
- DONE lasts exactly one cycle. Next state is IDLE, or the new state chosen by an accepted start in that same cycle (back-to-back operation).
- start is ignored while in RUN. The in-flight operation and its latched operands are unaffected.
- shift_out = data_reg. Intermediate values are visible during RUN; consumers sample shift_out only when done is high.
- ovf is driven only by SLA. For SRL, ROL and mode 3 it remains 0 for the whole operation.
- cnt never wraps: RUN is entered only with cnt >= 1, and cnt reaches 0 on the same edge the FSM leaves RUN.

## Timing
- Reset values: busy = 0, done = 0, shift_out = 0x0000, ovf = 0. Internal cnt = 0, mode_reg = 0, state = IDLE.
- Reset asserted mid-operation aborts immediately and asynchronously to the values above. No done pulse is produced.
- Latency: start is accepted at edge k. done is high in the cycle following edge k + N, where N = shift_val.
  - N = 0: done in the cycle after edge k.
  - N = 15: done follows 15 RUN cycles.
- busy is high for exactly N cycles; it is low for N = 0.
- Throughput: with start held high at each DONE, one result is produced every N + 1 cycles.
- No combinational path from inputs to outputs. All outputs are registered or decoded from the state register only.

## Test plan
- SRL: shift_in = 0x8001, shift_val = 4, mode = 0 → busy high for 4 cycles; done pulses at edge k+4; shift_out = 0x0800; ovf = 0.
- ROL: 0x8001 by 1 → shift_out = 0x0003. ROL 0x1234 by 8 → 0x3412; done at edge k+8.
- SLA overflow:
  - 0x4000 by 1 → 0x8000, ovf = 1.
  - 0xFFF0 by 3 → 0xFF80, ovf = 0.
  - 0x2000 by 3 → 0x0000, ovf = 1; the flag is set at step 2 and stays set.
- shift_val = 0 (any mode, shift_in = 0xA5A5) → done in the cycle after start; busy never asserted; shift_out = 0xA5A5. Mode 3 with 0xA5A5 by 5 → 0xA5A5, done at edge k+5.
- Protocol boundaries:
  - start pulsed with new operands during RUN → ignored; the original result is delivered.
  - start held high at DONE with 0x0001, SRL by 1 → accepted back-to-back; second done 2 cycles later, shift_out = 0x0000.
- Reset: rst_n dropped mid-way through a 10-cycle SLA → all outputs read 0 immediately, without waiting for a clock edge. After release, the FSM is in IDLE and the next start completes normally.
